// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared execute-stage constants plus the multiply sequencer state encoding
package mul_sequencer_pkg;

    localparam int REGISTER_FILE_LEN = 32;
    localparam int EXEC_COMMAND_LEN  = 4;
    localparam int STATUS_REG_LEN    = 4;

    localparam logic [EXEC_COMMAND_LEN-1:0] EXEC_ADD = 4'h4;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_ITER = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Status word order matches the ALU status output: {Z, C, N, V}
    function automatic logic [STATUS_REG_LEN-1:0] pack_status(
        input logic z, input logic c, input logic n, input logic v);
        return {z, c, n, v};
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-and-add MUL/MLA controller that borrows the shared ALU as its adder
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_W = REGISTER_FILE_LEN,
    parameter int CNT_W  = 5,
    parameter int STAT_W = STATUS_REG_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        accumulate,
    input  logic [DATA_W-1:0]           mcand_in,
    input  logic [DATA_W-1:0]           mplier_in,
    input  logic [DATA_W-1:0]           acc_in,
    input  logic [STAT_W-1:0]           status_in,
    input  logic [DATA_W-1:0]           alu_res,
    output logic                        alu_own,
    output logic [DATA_W-1:0]           alu_val_1,
    output logic [DATA_W-1:0]           alu_val_2,
    output logic [EXEC_COMMAND_LEN-1:0] alu_exec_cmd,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_W-1:0]           result,
    output logic [STAT_W-1:0]           status_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [STAT_W-1:0] stat_calc;
    logic              unused_status;

    // Only C and V of the incoming status survive; Z and N are recomputed from the product
    assign unused_status = ^{status_in[3], status_in[1]};
    assign stat_calc = pack_status(product_q == '0, status_in[2], product_q[DATA_W-1], status_in[0]);

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MUL_IDLE;
            product_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            stat_q    <= '0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            stat_q    <= stat_d;
        end
    end

    // Next state, one ALU add per ITER cycle, and the stall/ownership outputs
    always_comb begin
        state_d      = state_q;
        product_d    = product_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        stat_d       = stat_q;
        busy         = 1'b0;
        alu_own      = 1'b0;
        done         = 1'b0;
        alu_val_1    = '0;
        alu_val_2    = '0;
        alu_exec_cmd = EXEC_ADD;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d   = mcand_in;
                    mplier_d  = mplier_in;
                    cnt_d     = '0;
                    product_d = accumulate ? acc_in : '0;
                    state_d   = MUL_ITER;
                end
            end
            MUL_ITER: begin
                busy      = 1'b1;
                alu_own   = 1'b1;
                alu_val_1 = product_q;
                alu_val_2 = mplier_q[0] ? mcand_q : '0;
                product_d = alu_res;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                state_d   = (mplier_d == '0 || cnt_q == CNT_LAST) ? MUL_DONE : MUL_ITER;
            end
            MUL_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                res_d   = product_q;
                stat_d  = stat_calc;
                state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign result     = done ? product_q : res_q;
    assign status_out = done ? stat_calc : stat_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: table-driven and scoreboarded check of the MUL/MLA sequencer
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    logic        clk, rst, start, accumulate;
    logic [31:0] mcand_in, mplier_in, acc_in, alu_res, alu_val_1, alu_val_2, result;
    logic [3:0]  status_in, status_out, alu_exec_cmd;
    logic        alu_own, busy, done;

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .mcand_in(mcand_in), .mplier_in(mplier_in), .acc_in(acc_in),
        .status_in(status_in), .alu_res(alu_res), .alu_own(alu_own),
        .alu_val_1(alu_val_1), .alu_val_2(alu_val_2), .alu_exec_cmd(alu_exec_cmd),
        .busy(busy), .done(done), .result(result), .status_out(status_out)
    );

    // External shared ALU performing ADD, carry dropped
    assign alu_res = alu_val_1 + alu_val_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        acc;
        logic [31:0] a, b, c;
        logic [3:0]  st;
        logic [31:0] res;
        logic [3:0]  stat;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  stat;
        int          cyc;
        int          t0;
    } exp_t;

    exp_t q[$];
    vec_t v[6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_now  = 0;
    int   own_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc_now++;

    // Scoreboard side: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!rst) begin
            if (alu_own) begin
                own_cnt++;
                chk("alu_cmd", 64'(alu_exec_cmd), 64'(EXEC_ADD));
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("status", 64'(status_out), 64'(e.stat));
                    chk("latency", 64'(cyc_now - e.t0), 64'(e.cyc));
                    chk("own_cycles", 64'(own_cnt), 64'(e.cyc - 1));
                    chk("busy_in_done", 64'(busy), 64'd1);
                end
                own_cnt = 0;
            end
        end
    end

    task automatic launch(input logic acc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [3:0] st,
                          input logic [31:0] er, input logic [3:0] es, input int ec);
        exp_t e;
        start      = 1'b1;
        accumulate = acc;
        mcand_in   = a;
        mplier_in  = b;
        acc_in     = c;
        status_in  = st;
        e.res = er; e.stat = es; e.cyc = ec; e.t0 = cyc_now;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending ops expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        v[0] = '{1'b0, 32'd3,        32'd5,        32'd0,   4'b0000, 32'd15,  4'b0000, 4};
        v[1] = '{1'b0, 32'd9,        32'd0,        32'd0,   4'b0000, 32'd0,   4'b1000, 2};
        v[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,   4'b0101, 32'd1,   4'b0101, 33};
        v[3] = '{1'b1, 32'd7,        32'd6,        32'd100, 4'b0000, 32'd142, 4'b0000, 4};
        v[4] = '{1'b0, 32'h00010000, 32'h00010000, 32'd0,   4'b0000, 32'd0,   4'b1000, 18};
        v[5] = '{1'b0, 32'h80000000, 32'd1,        32'd0,   4'b0000, 32'h80000000, 4'b0010, 2};
        rst = 1'b1; start = 1'b0; accumulate = 1'b0;
        mcand_in = '0; mplier_in = '0; acc_in = '0; status_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_own", 64'(alu_own), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_status", 64'(status_out), 64'd0);
        chk("rst_cmd", 64'(alu_exec_cmd), 64'(EXEC_ADD));
        chk("rst_val1", 64'(alu_val_1), 64'd0);
        chk("rst_val2", 64'(alu_val_2), 64'd0);
        for (int i = 0; i < 6; i++) begin
            launch(v[i].acc, v[i].a, v[i].b, v[i].c, v[i].st, v[i].res, v[i].stat, v[i].cyc);
            wait_idle();
            chk("idle_busy", 64'(busy), 64'd0);
        end
        // start pulses during ITER must not disturb a running 5 x 5
        launch(1'b0, 32'd5, 32'd5, 32'd0, 4'b0000, 32'd25, 4'b0000, 4);
        @(negedge clk);
        start = 1'b1; accumulate = 1'b1; mcand_in = 32'd7; mplier_in = 32'd7; acc_in = 32'd9;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60 && !done; k++) @(negedge clk);
        chk("ignored_start_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("post_done_idle", 64'(busy), 64'd0);
        launch(1'b0, 32'd2, 32'd3, 32'd0, 4'b0000, 32'd6, 4'b0000, 3);
        wait_idle();
        // asynchronous abort in the middle of a long operation
        launch(1'b0, 32'hFFFF, 32'hFFFF, 32'd0, 4'b0000, 32'hFFFE0001, 4'b0010, 17);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_own", 64'(alu_own), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        q.delete();
        own_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        launch(1'b0, 32'd2, 32'd3, 32'd0, 4'b0000, 32'd6, 4'b0000, 3);
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle MUL/MLA controller that reuses the shared execute-stage ALU as its adder. It computes the low 32 bits of a product by shift-and-add, one ALU ADD per cycle.
- Sits beside the ALU in the execute stage. While it runs, it owns the ALU operand and command inputs and stalls the pipeline.
- On completion it returns the result and NZCV-format status for writeback and the status register.

Parameters:
- DATA_W, 32, operand/result width; equals register-file word width.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal DATA_W.
- STAT_W, 4, status width; order {Z,C,N,V}, the same as the ALU status output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- accumulate  in  1  1 = MLA (product + acc_in), 0 = MUL.
- mcand_in  in  DATA_W  multiplicand (Rm).
- mplier_in  in  DATA_W  multiplier (Rs).
- acc_in  in  DATA_W  accumulator addend (Rn).
- status_in  in  STAT_W  current status register; its C and V bits are passed through.
- alu_res  in  DATA_W  shared ALU result.
- alu_own  out  1  1 = the execute mux routes the sequencer's operands and command to the ALU.
- alu_val_1  out  DATA_W  ALU operand 1.
- alu_val_2  out  DATA_W  ALU operand 2.
- alu_exec_cmd  out  EXEC_COMMAND_LEN  ALU command.
- busy  out  1  stall request to the hazard/pipeline control.
- done  out  1  one-cycle pulse; result and status_out are valid in this cycle.
- result  out  DATA_W  product (low DATA_W bits).
- status_out  out  STAT_W  {Z, C from status_in, N, V from status_in}.

Behaviour:
- Reset:
  - state = IDLE; product, mcand, mplier, cnt all cleared.
  - All outputs 0 except alu_exec_cmd = EXEC_ADD.
  - rst asserted mid-operation aborts at once. No done pulse is produced, and the first post-reset cycle is IDLE.
- State IDLE:
  - busy = 0, alu_own = 0, done = 0.
  - On start = 1:
    - mcand <= mcand_in, mplier <= mplier_in, cnt <= 0.
    - product <= accumulate ? acc_in : 0.
    - Go to ITER.
- State ITER:
  - busy = 1, alu_own = 1.
  - ALU drive: alu_val_1 = product; alu_val_2 = mplier[0] ? mcand : 0; alu_exec_cmd = EXEC_ADD.
  - ALU path is combinational. Each cycle:
    - product <= alu_res (carry and overflow discarded; modulo 2^DATA_W).
    - mcand <= mcand << 1 (zero-fill).
    - mplier <= mplier >> 1 (logical).
    - cnt <= cnt + 1.
  - Exit to DONE when (mplier >> 1) == 0 or cnt == DATA_W-1. Otherwise stay in ITER.
  - Iterations = max(1, index of highest set bit of mplier_in + 1); maximum DATA_W.
- State DONE:
  - busy = 1, alu_own = 0, done = 1.
  - result = product.
  - status_out: Z = (product == 0), N = product[DATA_W-1], C = status_in[2], V = status_in[0].
  - Unconditionally go to IDLE next cycle.
- Outputs outside DONE: result and status_out hold their last DONE values; both are 0 after reset.
- Latency: start in cycle 0 → done in cycle (iterations + 1). A new start is accepted the cycle after done.
- start in ITER or DONE is ignored; the bench must check that no state or operand change occurs.
- accumulate, operands and status_in are sampled only at start, except status_in, which is sampled in DONE.
- Operands are treated as unsigned. The low 32 bits are identical for signed inputs, so no sign handling is needed.

Decomposition:
- Shared constants package/header:
  - Add MUL_IDLE, MUL_ITER, MUL_DONE state encodings (2 bits).
  - Reuse the existing EXEC_ADD, REGISTER_FILE_LEN, EXEC_COMMAND_LEN and STATUS_REG_LEN definitions.
- No sub-module: one FSM plus datapath registers.
- The ALU is not instantiated inside; it is shared through the alu_own mux in the execute stage.

Test Plan:
- MUL 3 × 5, accumulate = 0, status_in = 4'b0000:
  - 3 ITER cycles; done at cycle 4.
  - result = 15, status_out = 4'b0000.
  - alu_own high for cycles 1–3 only.
- MUL 9 × 0:
  - 1 iteration; done at cycle 2.
  - result = 0, status_out Z = 1, N = 0.
- MUL 0xFFFFFFFF × 0xFFFFFFFF with status_in = 4'b0101:
  - 32 iterations; done at cycle 33.
  - result = 0x00000001, status_out = 4'b0101 (C and V passed through).
- MLA 7 × 6 + 100:
  - result = 142.
  - MUL 0x00010000 × 0x00010000 → result = 0, Z = 1 (wrap-around).
  - MUL 0x80000000 × 1 → N = 1.
- start pulsed at cycles 2 and 3 during a 5 × 5 operation:
  - Ignored; single done with result = 25.
  - A new start the cycle after done is accepted.
- rst asserted during ITER of 0xFFFF × 0xFFFF:
  - busy, alu_own and done drop to 0 immediately (asynchronous), with no done pulse.
  - A following 2 × 3 yields 6.
